trenc_resync_timer: RTL and testbench

//  Downstream consumer of the APB control register outputs in the trace encoder.

---
 rtl/trenc_resync_timer.sv | 145 ++++++++++++++
 tb/tb_trenc_resync_timer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/trenc_resync_timer.sv
// trenc_resync_timer
// Turns trace enable/start and the programmed expire time into sync requests
// for the packet encoder. It issues one start-of-trace sync, then a periodic
// resync every tetime active cycles. It also runs the free-running trace
// timestamp and captures that timestamp at every sync handshake.
module trenc_resync_timer #(
  parameter int unsigned TIME_WIDTH = 32,
  parameter int unsigned TS_WIDTH   = 40
) (
  input  logic                  trenc_pclk_i,
  input  logic                  trenc_prstn_i,
  input  logic                  trenc_trctrl_enable_i,
  input  logic                  trenc_trctrl_start_i,
  input  logic                  trenc_trctrl_tscon_i,
  input  logic [TIME_WIDTH-1:0] trenc_tetime_i,
  input  logic                  trenc_sync_ack_i,
  output logic                  trenc_sync_req_o,
  output logic [1:0]            trenc_sync_reason_o,
  output logic                  trenc_stop_o,
  output logic [TS_WIDTH-1:0]   trenc_timestamp_o,
  output logic [TS_WIDTH-1:0]   trenc_sync_ts_o
);

  typedef enum logic [1:0] {
    ST_OFF = 2'b00,
    ST_REQ = 2'b01,
    ST_RUN = 2'b10
  } state_e;

  localparam logic [1:0] REASON_START  = 2'b01;
  localparam logic [1:0] REASON_EXPIRE = 2'b10;

  state_e                state_r;
  state_e                state_nxt_s;
  logic [TIME_WIDTH-1:0] cnt_r;
  logic [TIME_WIDTH-1:0] cnt_nxt_s;
  logic [1:0]            reason_r;
  logic [1:0]            reason_nxt_s;
  logic                  stop_r;
  logic                  stop_nxt_s;
  logic                  req_r;
  logic [TS_WIDTH-1:0]   ts_r;
  logic [TS_WIDTH-1:0]   sync_ts_r;
  logic [TS_WIDTH-1:0]   sync_ts_nxt_s;
  logic                  active_s;
  logic                  cnt_sat_s;
  logic                  expire_s;

  // Trace is active only while both enable and start are set (unregistered).
  assign active_s  = trenc_trctrl_enable_i & trenc_trctrl_start_i;
  assign cnt_sat_s = &cnt_r;
  // A >= compare so that shrinking tetime below the count fires at once.
  assign expire_s  = (trenc_tetime_i != {TIME_WIDTH{1'b0}}) &&
                     (cnt_r >= (trenc_tetime_i - TIME_WIDTH'(1)));

  // Next-state, counter, reason, stop and capture decisions for the sync FSM.
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    reason_nxt_s  = reason_r;
    stop_nxt_s    = 1'b0;
    sync_ts_nxt_s = sync_ts_r;
    case (state_r)
      ST_OFF: begin
        cnt_nxt_s = {TIME_WIDTH{1'b0}};
        if (active_s) begin
          state_nxt_s  = ST_REQ;
          reason_nxt_s = REASON_START;
        end else begin
          state_nxt_s  = ST_OFF;
        end
      end
      ST_REQ: begin
        // A raised request is never withdrawn; only the ack moves us on.
        if (trenc_sync_ack_i) begin
          sync_ts_nxt_s = ts_r;
          cnt_nxt_s     = {TIME_WIDTH{1'b0}};
          if (active_s) begin
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_OFF;
            stop_nxt_s  = 1'b1;
          end
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_RUN: begin
        if (!active_s) begin
          state_nxt_s = ST_OFF;
          stop_nxt_s  = 1'b1;
          cnt_nxt_s   = {TIME_WIDTH{1'b0}};
        end else if (expire_s) begin
          state_nxt_s  = ST_REQ;
          reason_nxt_s = REASON_EXPIRE;
        end else if (!cnt_sat_s) begin
          cnt_nxt_s = cnt_r + TIME_WIDTH'(1);
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      default: begin
        state_nxt_s = ST_OFF;
        cnt_nxt_s   = {TIME_WIDTH{1'b0}};
      end
    endcase
  end

  // FSM state, counter and registered handshake outputs.
  always_ff @(posedge trenc_pclk_i or negedge trenc_prstn_i) begin
    if (!trenc_prstn_i) begin
      state_r   <= ST_OFF;
      cnt_r     <= {TIME_WIDTH{1'b0}};
      reason_r  <= 2'b00;
      stop_r    <= 1'b0;
      req_r     <= 1'b0;
      sync_ts_r <= {TS_WIDTH{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      reason_r  <= reason_nxt_s;
      stop_r    <= stop_nxt_s;
      req_r     <= (state_nxt_s == ST_REQ);
      sync_ts_r <= sync_ts_nxt_s;
    end
  end

  // Free-running timestamp, cleared whenever timestamping is disabled.
  always_ff @(posedge trenc_pclk_i or negedge trenc_prstn_i) begin
    if (!trenc_prstn_i) begin
      ts_r <= {TS_WIDTH{1'b0}};
    end else if (trenc_trctrl_tscon_i) begin
      ts_r <= ts_r + TS_WIDTH'(1);
    end else begin
      ts_r <= {TS_WIDTH{1'b0}};
    end
  end

  assign trenc_sync_req_o    = req_r;
  assign trenc_sync_reason_o = reason_r;
  assign trenc_stop_o        = stop_r;
  assign trenc_timestamp_o   = ts_r;
  assign trenc_sync_ts_o     = sync_ts_r;

endmodule

// File: tb/tb_trenc_resync_timer.sv
// Self-checking bench for trenc_resync_timer: a per-cycle vector table for
// the handshake/expiry/stop sequences plus hand-written multi-cycle cases.
module tb_trenc_resync_timer;

  localparam int unsigned TW  = 16;
  localparam int unsigned TSW = 8;

  logic           clk;
  logic           rst_n;
  logic           en;
  logic           st;
  logic           tscon;
  logic [TW-1:0]  tetime;
  logic           ack;
  logic           req;
  logic [1:0]     reason;
  logic           stop;
  logic [TSW-1:0] ts;
  logic [TSW-1:0] sync_ts;

  int n_tests = 0;
  int n_fail  = 0;

  trenc_resync_timer #(.TIME_WIDTH(TW), .TS_WIDTH(TSW)) dut (
    .trenc_pclk_i          (clk),
    .trenc_prstn_i         (rst_n),
    .trenc_trctrl_enable_i (en),
    .trenc_trctrl_start_i  (st),
    .trenc_trctrl_tscon_i  (tscon),
    .trenc_tetime_i        (tetime),
    .trenc_sync_ack_i      (ack),
    .trenc_sync_req_o      (req),
    .trenc_sync_reason_o   (reason),
    .trenc_stop_o          (stop),
    .trenc_timestamp_o     (ts),
    .trenc_sync_ts_o       (sync_ts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       st;
    logic       ack;
    logic       exp_req;
    logic [1:0] exp_reason;
    logic       exp_stop;
  } vec_t;

  vec_t tbl[25];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int i, input logic e, input logic s, input logic a,
                         input logic r, input logic [1:0] rs, input logic sp);
    tbl[i].en = e; tbl[i].st = s; tbl[i].ack = a;
    tbl[i].exp_req = r; tbl[i].exp_reason = rs; tbl[i].exp_stop = sp;
  endtask

  initial begin
    int seen_req;
    int guard;

    // en st ack | req reason stop  (outputs seen after the edge sampling the inputs)
    set_vec(0,  1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0);
    for (int i = 1; i <= 5; i++) set_vec(i, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0);
    set_vec(6,  1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0);
    for (int i = 7; i <= 9; i++) set_vec(i, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
    set_vec(10, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0);
    set_vec(11, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0);
    for (int i = 12; i <= 14; i++) set_vec(i, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
    set_vec(15, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0);
    set_vec(16, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0);
    set_vec(17, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
    set_vec(18, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    set_vec(19, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0);
    set_vec(20, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0);
    set_vec(21, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1);
    set_vec(22, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    set_vec(23, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
    set_vec(24, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);

    // Reset state
    rst_n = 1'b0; en = 1'b0; st = 1'b0; tscon = 1'b0; tetime = 16'd4; ack = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    check("rst_req",     {31'd0, req},    32'd0);
    check("rst_reason",  {30'd0, reason}, 32'd0);
    check("rst_stop",    {31'd0, stop},   32'd0);
    check("rst_ts",      {24'd0, ts},     32'd0);
    check("rst_sync_ts", {24'd0, sync_ts}, 32'd0);

    // Table: start sync, expiry every tetime+1 cycles, stop paths, stray ack
    for (int i = 0; i < 25; i++) begin
      en = tbl[i].en; st = tbl[i].st; ack = tbl[i].ack;
      tick();
      check($sformatf("vec%0d_req", i),  {31'd0, req},  {31'd0, tbl[i].exp_req});
      check($sformatf("vec%0d_stop", i), {31'd0, stop}, {31'd0, tbl[i].exp_stop});
      if (tbl[i].exp_req)
        check($sformatf("vec%0d_reason", i), {30'd0, reason}, {30'd0, tbl[i].exp_reason});
    end

    // tetime=0: only the start sync, then shrink tetime below the count
    ack = 1'b0; tetime = 16'd0; en = 1'b1; st = 1'b1;
    tick();
    check("t0_start_req",    {31'd0, req},    32'd1);
    check("t0_start_reason", {30'd0, reason}, 32'd1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    seen_req = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (req) seen_req++;
    end
    check("t0_no_expire", seen_req, 32'd0);
    tetime = 16'd3;
    tick();
    check("shrink_req",    {31'd0, req},    32'd1);
    check("shrink_reason", {30'd0, reason}, 32'd2);
    st = 1'b0; ack = 1'b1;
    tick();
    check("shrink_stop", {31'd0, stop}, 32'd1);
    ack = 1'b0; tetime = 16'd0;
    tick();

    // Timestamp wrap, capture at handshake, clear when disabled
    tscon = 1'b0;
    tick();
    check("ts_clear0", {24'd0, ts}, 32'd0);
    tscon = 1'b1;
    repeat (255) tick();
    check("ts_max", {24'd0, ts}, 32'd255);
    tick();
    check("ts_wrap", {24'd0, ts}, 32'd0);
    st = 1'b1;
    tick();
    check("ts_req", {31'd0, req}, 32'd1);
    guard = 0;
    while (ts != 8'h25 && guard < 300) begin
      tick();
      guard++;
    end
    check("ts_reach_25", {24'd0, ts}, 32'h25);
    ack = 1'b1;
    tick();
    check("sync_ts_cap", {24'd0, sync_ts}, 32'h25);
    check("ts_after_ack", {24'd0, ts}, 32'h26);
    check("req_after_ack", {31'd0, req}, 32'd0);
    ack = 1'b0; tscon = 1'b0;
    tick();
    check("ts_off_clear", {24'd0, ts}, 32'd0);
    check("sync_ts_hold", {24'd0, sync_ts}, 32'h25);

    // Async reset mid-request
    st = 1'b0;
    tick();
    tscon = 1'b1; st = 1'b1;
    tick();
    check("pre_rst_req", {31'd0, req}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_req",  {31'd0, req},  32'd0);
    check("async_rst_ts",   {24'd0, ts},   32'd0);
    check("async_rst_stop", {31'd0, stop}, 32'd0);
    st = 1'b0; tscon = 1'b0;
    #3 rst_n = 1'b1;
    seen_req = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (req || stop) seen_req++;
    end
    check("post_rst_idle", seen_req, 32'd0);
    st = 1'b1;
    tick();
    check("post_rst_req",    {31'd0, req},    32'd1);
    check("post_rst_reason", {30'd0, reason}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
